// File: rtl/p4_router_pkg.sv
// Shared types and helpers for the P4 router ingress path.
package p4_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } ing_arb_state_e;

  localparam int PORT_IDX_WIDTH_DEF = 8;

  // Beats needed to carry one MTU-sized packet at the given bus width.
  function automatic int max_beats(input int mtu_bytes, input int data_bytes);
    return (mtu_bytes + data_bytes - 1) / data_bytes;
  endfunction

endpackage

// File: rtl/p4_router_rr_arb.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping.
module p4_router_rr_arb #(
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_valid
);

  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    // Walk from the farthest offset down so the closest requester wins last.
    for (int off = N - 1; off >= 0; off--) begin
      int idx;
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        grant_oh    = N'(1) << idx;
        grant_idx   = SEL_W'(idx);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/p4_router_ing_arb.sv
// Packet-granular round-robin merge of NUM_PORTS ingress AXIS streams with MTU truncation.
// Optional per-port packet counters: define P4_ROUTER_ING_ARB_STATS_EN.
module p4_router_ing_arb
  import p4_router_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_BYTES     = 64,
  parameter int PORT_IDX_WIDTH = PORT_IDX_WIDTH_DEF,
  parameter int MTU_BYTES      = 9600
) (
  input  logic                                    clk,
  input  logic                                    sresetn,
  input  logic [NUM_PORTS-1:0]                    in_tvalid,
  output logic [NUM_PORTS-1:0]                    in_tready,
  input  logic [NUM_PORTS-1:0][DATA_BYTES*8-1:0]  in_tdata,
  input  logic [NUM_PORTS-1:0][DATA_BYTES-1:0]    in_tkeep,
  input  logic [NUM_PORTS-1:0]                    in_tlast,
  output logic                                    out_tvalid,
  input  logic                                    out_tready,
  output logic [DATA_BYTES*8-1:0]                 out_tdata,
  output logic [DATA_BYTES-1:0]                   out_tkeep,
  output logic                                    out_tlast,
  output logic [PORT_IDX_WIDTH-1:0]               out_tuser,
  output logic [7:0]                              out_tid,
  output logic [7:0]                              out_tdest,
  output logic [NUM_PORTS-1:0]                    oversize_drop
`ifdef P4_ROUTER_ING_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][31:0]              pkt_cnt
`endif
);

  localparam int MAX_BEATS = max_beats(MTU_BYTES, DATA_BYTES);
  localparam int SEL_W     = $clog2(NUM_PORTS);
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);

  ing_arb_state_e          state_reg, state_next;
  logic [SEL_W-1:0]        lock_reg, lock_next;
  logic [SEL_W-1:0]        rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]        beat_cnt_reg, beat_cnt_next;

  logic                    out_tvalid_reg;
  logic [DATA_BYTES*8-1:0] out_tdata_reg;
  logic [DATA_BYTES-1:0]   out_tkeep_reg;
  logic                    out_tlast_reg;
  logic [PORT_IDX_WIDTH-1:0] out_tuser_reg;
  logic [NUM_PORTS-1:0]    oversize_drop_reg;

  logic [NUM_PORTS-1:0]    arb_oh;
  logic [SEL_W-1:0]        arb_idx;
  logic                    arb_valid;

  logic                    load, accept, last_in, truncate;
  logic [SEL_W-1:0]        sel, sel_inc;
  logic [NUM_PORTS-1:0]    ready_vec;

  p4_router_rr_arb #(
    .N     (NUM_PORTS),
    .SEL_W (SEL_W)
  ) u_rr_arb (
    .req         (in_tvalid),
    .ptr         (rr_ptr_reg),
    .grant_oh    (arb_oh),
    .grant_idx   (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    load    = !out_tvalid_reg || out_tready;
    // In IDLE the grant comes straight from the arbiter so a new packet starts without a bubble.
    sel     = (state_reg == IDLE) ? arb_idx : lock_reg;
    sel_inc = (sel == SEL_W'(NUM_PORTS - 1)) ? '0 : sel + 1'b1;

    ready_vec = '0;
    case (state_reg)
      IDLE:    if (load && arb_valid) ready_vec = arb_oh;
      PASS:    ready_vec[lock_reg] = load;
      DROP:    ready_vec[lock_reg] = 1'b1;
      default: ready_vec = '0;
    endcase
    in_tready = sresetn ? ready_vec : '0;

    accept   = in_tvalid[sel] && in_tready[sel];
    last_in  = in_tlast[sel];
    truncate = accept && (state_reg != DROP) && !last_in &&
               (beat_cnt_reg == CNT_W'(MAX_BEATS - 1));

    state_next    = state_reg;
    lock_next     = lock_reg;
    rr_ptr_next   = rr_ptr_reg;
    beat_cnt_next = beat_cnt_reg;

    if (accept) begin
      if (last_in) begin
        state_next    = IDLE;
        rr_ptr_next   = sel_inc;
        beat_cnt_next = '0;
      end else if (state_reg == DROP) begin
        state_next = DROP;
      end else if (truncate) begin
        state_next    = DROP;
        lock_next     = sel;
        beat_cnt_next = '0;
      end else begin
        state_next    = PASS;
        lock_next     = sel;
        beat_cnt_next = beat_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_reg         <= IDLE;
      lock_reg          <= '0;
      rr_ptr_reg        <= '0;
      beat_cnt_reg      <= '0;
      out_tvalid_reg    <= 1'b0;
      out_tdata_reg     <= '0;
      out_tkeep_reg     <= '0;
      out_tlast_reg     <= 1'b0;
      out_tuser_reg     <= '0;
      oversize_drop_reg <= '0;
    end else begin
      state_reg    <= state_next;
      lock_reg     <= lock_next;
      rr_ptr_reg   <= rr_ptr_next;
      beat_cnt_reg <= beat_cnt_next;
      if (load) begin
        out_tvalid_reg <= accept && (state_reg != DROP);
        if (accept && (state_reg != DROP)) begin
          out_tdata_reg <= in_tdata[sel];
          out_tkeep_reg <= in_tkeep[sel];
          out_tlast_reg <= last_in || truncate;
          out_tuser_reg <= PORT_IDX_WIDTH'(sel);
        end
      end
      oversize_drop_reg <= truncate ? (NUM_PORTS'(1) << sel) : '0;
    end
  end

  assign out_tvalid    = out_tvalid_reg;
  assign out_tdata     = out_tdata_reg;
  assign out_tkeep     = out_tkeep_reg;
  assign out_tlast     = out_tlast_reg;
  assign out_tuser     = out_tuser_reg;
  assign out_tid       = '0;
  assign out_tdest     = '0;
  assign oversize_drop = oversize_drop_reg;

`ifdef P4_ROUTER_ING_ARB_STATS_EN
  logic        pkt_end;
  logic [31:0] pkt_cnt_reg [NUM_PORTS];

  // A truncated packet counts once, at its forced tlast; the discarded tail does not.
  assign pkt_end = accept && (state_reg != DROP) && (last_in || truncate);

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
    always_ff @(posedge clk or negedge sresetn) begin
      if (!sresetn) begin
        pkt_cnt_reg[gi] <= '0;
      end else if (pkt_end && (sel == SEL_W'(gi)) && (pkt_cnt_reg[gi] != '1)) begin
        pkt_cnt_reg[gi] <= pkt_cnt_reg[gi] + 32'd1;
      end
    end
    assign pkt_cnt[gi] = pkt_cnt_reg[gi];
  end
`endif

endmodule

// File: tb/tb_p4_router_ing_arb.sv
// Scoreboard bench for p4_router_ing_arb: per-port expected queues filled at enqueue time.
module tb_p4_router_ing_arb;

  localparam int NP  = 4;
  localparam int DB  = 64;
  localparam int DW  = DB * 8;
  localparam int MTU = 9600;
  localparam int MAXB = 150;

  typedef struct {
    logic [DW-1:0] data;
    logic [DB-1:0] keep;
    logic          last;
  } beat_t;

  logic                    clk;
  logic                    sresetn;
  logic [NP-1:0]           in_tvalid;
  logic [NP-1:0]           in_tready;
  logic [NP-1:0][DW-1:0]   in_tdata;
  logic [NP-1:0][DB-1:0]   in_tkeep;
  logic [NP-1:0]           in_tlast;
  logic                    out_tvalid;
  logic                    out_tready;
  logic [DW-1:0]           out_tdata;
  logic [DB-1:0]           out_tkeep;
  logic                    out_tlast;
  logic [7:0]              out_tuser;
  logic [7:0]              out_tid;
  logic [7:0]              out_tdest;
  logic [NP-1:0]           oversize_drop;
`ifdef P4_ROUTER_ING_ARB_STATS_EN
  logic [NP-1:0][31:0]     pkt_cnt;
`endif

  p4_router_ing_arb #(
    .NUM_PORTS      (NP),
    .DATA_BYTES     (DB),
    .PORT_IDX_WIDTH (8),
    .MTU_BYTES      (MTU)
  ) dut (
    .clk           (clk),
    .sresetn       (sresetn),
    .in_tvalid     (in_tvalid),
    .in_tready     (in_tready),
    .in_tdata      (in_tdata),
    .in_tkeep      (in_tkeep),
    .in_tlast      (in_tlast),
    .out_tvalid    (out_tvalid),
    .out_tready    (out_tready),
    .out_tdata     (out_tdata),
    .out_tkeep     (out_tkeep),
    .out_tlast     (out_tlast),
    .out_tuser     (out_tuser),
    .out_tid       (out_tid),
    .out_tdest     (out_tdest),
    .oversize_drop (oversize_drop)
`ifdef P4_ROUTER_ING_ARB_STATS_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t src_q [NP][$];
  beat_t exp_q [NP][$];
  int    seq_log [$];
  int    out_cyc [$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    pkt_id = 0;
  int    ov_cnt [NP];
  int    sent_pkts [NP];
  logic  [NP-1:0] acc_last;
  logic  in_pkt = 1'b0;
  int    cur_port = 0;
  logic  stall_en = 1'b0;
  logic  rand_rdy = 1'b0;

  task automatic expect_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_pkt(input int p, input int nbeats);
    beat_t b;
    logic [DB-1:0] k;
    logic [31:0] tag;
    for (int i = 0; i < nbeats; i++) begin
      tag = {p[7:0], pkt_id[11:0], i[11:0]};
      k = '1;
      b.data = {16{tag}};
      b.keep = (i == nbeats - 1) ? (k >> p) : k;
      b.last = (i == nbeats - 1);
      src_q[p].push_back(b);
      if (i < MAXB) begin
        b.last = (i == nbeats - 1) || (i == MAXB - 1);
        exp_q[p].push_back(b);
      end
    end
    pkt_id++;
    sent_pkts[p]++;
  endtask

  task automatic check_out();
    int p;
    beat_t e;
    p = int'(out_tuser);
    expect_eq("tid_tdest", {out_tid, out_tdest}, '0);
    if (!in_pkt) begin
      seq_log.push_back(p);
      cur_port = p;
      in_pkt = 1'b1;
    end else begin
      expect_eq("no_interleave", p, cur_port);
    end
    out_cyc.push_back(cyc);
    expect_eq("exp_avail", (p < NP) && (exp_q[p % NP].size() > 0), 1);
    if (p < NP && exp_q[p].size() > 0) begin
      e = exp_q[p].pop_front();
      expect_eq("data", out_tdata, e.data);
      expect_eq("keep", out_tkeep, e.keep);
      expect_eq("last", out_tlast, e.last);
    end
    if (out_tlast) in_pkt = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() > 0 && !(stall_en && $urandom_range(0, 3) == 0)) begin
        in_tvalid[p] = 1'b1;
        in_tdata[p]  = src_q[p][0].data;
        in_tkeep[p]  = src_q[p][0].keep;
        in_tlast[p]  = src_q[p][0].last;
      end else begin
        in_tvalid[p] = 1'b0;
        in_tdata[p]  = '0;
        in_tkeep[p]  = '0;
        in_tlast[p]  = 1'b0;
      end
    end
    out_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) ov_cnt[p] += int'(oversize_drop[p]);
    acc_last = in_tvalid & in_tready;
    for (int p = 0; p < NP; p++) if (acc_last[p]) void'(src_q[p].pop_front());
    if (out_tvalid && out_tready) check_out();
  endtask

  function automatic int pending();
    int n = 0;
    for (int p = 0; p < NP; p++) n += src_q[p].size() + exp_q[p].size();
    return n;
  endfunction

  task automatic drain(input string tag);
    int guard = 0;
    while (pending() > 0 && guard < 4000) begin
      step();
      guard++;
    end
    expect_eq({tag, "_drain_done"}, pending(), 0);
  endtask

  task automatic clear_bench();
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
      ov_cnt[p] = 0;
      sent_pkts[p] = 0;
    end
    seq_log.delete();
    out_cyc.delete();
    in_pkt = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sresetn = 1'b0;
    in_tvalid = '1;
    #1;
    expect_eq("rst_out_tvalid", out_tvalid, 0);
    expect_eq("rst_in_tready", in_tready, 0);
    expect_eq("rst_oversize", oversize_drop, 0);
    expect_eq("rst_rr_ptr", dut.rr_ptr_reg, 0);
    clear_bench();
    repeat (2) @(negedge clk);
    in_tvalid = '0;
    sresetn = 1'b1;
  endtask

  initial begin
    sresetn = 1'b0;
    in_tvalid = '0;
    in_tdata = '0;
    in_tkeep = '0;
    in_tlast = '0;
    out_tready = 1'b1;
    acc_last = '0;
    for (int p = 0; p < NP; p++) begin
      ov_cnt[p] = 0;
      sent_pkts[p] = 0;
    end
    repeat (3) @(negedge clk);
    do_reset();

    // 1: ports 0 and 2 each hold a 3-beat packet
    send_pkt(0, 3);
    send_pkt(2, 3);
    drain("t1");
    expect_eq("t1_beats", out_cyc.size(), 6);
    if (out_cyc.size() == 6) expect_eq("t1_span", out_cyc[5] - out_cyc[0], 5);
    expect_eq("t1_first_port", (seq_log.size() > 0) ? seq_log[0] : -1, 0);
    expect_eq("t1_second_port", (seq_log.size() > 1) ? seq_log[1] : -1, 2);
    expect_eq("t1_rr_ptr", dut.rr_ptr_reg, 3);

    // 2: all ports continuously valid with single-beat packets
    do_reset();
    for (int i = 0; i < 25; i++)
      for (int p = 0; p < NP; p++) send_pkt(p, 1);
    drain("t2");
    expect_eq("t2_pkts", seq_log.size(), 100);
    for (int i = 0; i < seq_log.size(); i++) expect_eq("t2_order", seq_log[i], i % NP);

    // 3: random backpressure and source stalls across three ports
    do_reset();
    stall_en = 1'b1;
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++)
      for (int p = 0; p < 3; p++) send_pkt(p, int'($urandom_range(1, 6)));
    drain("t3");
    expect_eq("t3_pkts", seq_log.size(), 24);
    stall_en = 1'b0;
    rand_rdy = 1'b0;

    // 4: 200-beat packet on port 1 is truncated at MAX_BEATS, then a normal packet follows
    do_reset();
    send_pkt(1, 200);
    send_pkt(1, 3);
    drain("t4");
    expect_eq("t4_ov_port1", ov_cnt[1], 1);
    expect_eq("t4_ov_others", ov_cnt[0] + ov_cnt[2] + ov_cnt[3], 0);
    expect_eq("t4_beats_out", out_cyc.size(), MAXB + 3);
    expect_eq("t4_pkts", seq_log.size(), 2);

    // 5: exactly MAX_BEATS with tlast on the last beat passes intact
    send_pkt(3, MAXB);
    drain("t5");
    expect_eq("t5_ov_port3", ov_cnt[3], 0);
    expect_eq("t5_beats_out", out_cyc.size(), 2 * MAXB + 3);
`ifdef P4_ROUTER_ING_ARB_STATS_EN
    for (int p = 0; p < NP; p++) expect_eq("t5_pkt_cnt", pkt_cnt[p], sent_pkts[p]);
`endif

    // 6: reset mid-packet on port 0, then port 1 must win immediately
    do_reset();
    send_pkt(0, 10);
    repeat (4) step();
    @(negedge clk);
    sresetn = 1'b0;
    #1;
    expect_eq("t6_out_tvalid", out_tvalid, 0);
    expect_eq("t6_in_tready", in_tready, 0);
    expect_eq("t6_state", dut.state_reg, 0);
    clear_bench();
    in_tvalid = '0;
    repeat (2) @(negedge clk);
    sresetn = 1'b1;
    send_pkt(1, 2);
    step();
    expect_eq("t6_first_grant", acc_last, 4'b0010);
    drain("t6");
    expect_eq("t6_port", (seq_log.size() > 0) ? seq_log[0] : -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
